// File: rtl/turn_lever_ctrl_pkg.sv
// turn_lever_pkg: shared types and defaults for the turn-lever front end.
//   state_e  - controller FSM states
//   dir_e    - latched request direction
//   DEF_*    - default timing parameters
//   cw()     - counter width for a terminal count, never narrower than 1 bit
package turn_lever_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      COMFORT = 2'd2,
      CANCEL  = 2'd3
   } state_e;

   typedef enum logic {
      L = 1'b0,
      R = 1'b1
   } dir_e;

   localparam int DEF_DB_CYCLES      = 4;
   localparam int DEF_TAP_CYCLES     = 8;
   localparam int DEF_COMFORT_CYCLES = 12;
   localparam int DEF_TIMEOUT        = 256;

   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/turn_lever_ctrl_if.sv
// turn_lever_ctrl_if: lever contacts in, lamp requests out.
//   lever_left/lever_right - raw, asynchronous, bouncing contacts
//   left/right             - mutually exclusive turn requests
//   cancelled              - timeout hit while lever still held
//   master: drives the contacts (lever side); slave: the controller
interface turn_lever_ctrl_if;
   logic lever_left;
   logic lever_right;
   logic left;
   logic right;
   logic cancelled;

   modport master (output lever_left, lever_right, input left, right, cancelled);
   modport slave  (input lever_left, lever_right, output left, right, cancelled);
endinterface

// File: rtl/turn_lever_ctrl_debounce.sv
// lever_debounce: 2-FF synchroniser followed by a debounce counter.
//   clk, reset - system clock, asynchronous active-high reset
//   raw        - asynchronous contact input
//   db         - debounced level; follows raw after DB_CYCLES consecutive
//                differing synchronised samples
module lever_debounce
   import turn_lever_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic db
);

   localparam int            CW       = cw(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          db_q,    db_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      db_d    = db_q;
      cnt_d   = '0;
      // Any sample matching the accepted level restarts the qualification run.
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db = db_q;

endmodule

// File: rtl/turn_lever_ctrl.sv
// turn_lever_ctrl: turns raw lever contacts into clean left/right requests.
//   clk, reset - system clock, asynchronous active-high reset
//   bus        - slave side of turn_lever_ctrl_if (contacts in, requests out)
// Both contacts are synchronised and debounced, conflicting requests drop to
// IDLE, short taps get a comfort extension, and long holds auto-cancel.
module turn_lever_ctrl
   import turn_lever_pkg::*;
#(
   parameter int DB_CYCLES      = DEF_DB_CYCLES,
   parameter int TAP_CYCLES     = DEF_TAP_CYCLES,
   parameter int COMFORT_CYCLES = DEF_COMFORT_CYCLES,
   parameter int TIMEOUT        = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          reset,
   turn_lever_ctrl_if.slave bus
);

   localparam int             TW      = cw(TIMEOUT);
   localparam int             CCW     = cw(COMFORT_CYCLES);
   localparam logic [TW-1:0]  TAP_T   = TW'(TAP_CYCLES);
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [CCW-1:0] C_LAST  = CCW'(COMFORT_CYCLES - 1);

   logic db_l, db_r;

   lever_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.lever_left),
      .db    (db_l)
   );

   lever_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.lever_right),
      .db    (db_r)
   );

   state_e          state_q, state_d;
   dir_e            dir_q,   dir_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [CCW-1:0]  ccnt_q,  ccnt_d;
   logic            own, opp;

   // Contacts relative to the latched direction.
   assign own = (dir_q == L) ? db_l : db_r;
   assign opp = (dir_q == L) ? db_r : db_l;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      timer_d = timer_q;
      ccnt_d  = ccnt_q;
      case (state_q)
         IDLE: begin
            if (db_l && !db_r) begin
               state_d = ACTIVE;
               dir_d   = L;
               timer_d = '0;
            end else if (db_r && !db_l) begin
               state_d = ACTIVE;
               dir_d   = R;
               timer_d = '0;
            end
         end
         ACTIVE: begin
            if (opp) begin
               state_d = IDLE;
            end else if (!own) begin
               if (timer_q < TAP_T) begin
                  state_d = COMFORT;
                  ccnt_d  = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (timer_q == TO_LAST) begin
               state_d = CANCEL;
            end else begin
               // Only advanced while staying, so the terminal count never wraps.
               timer_d = timer_q + 1'b1;
            end
         end
         COMFORT: begin
            if (opp) begin
               state_d = IDLE;
            end else if (own) begin
               state_d = ACTIVE;
               timer_d = '0;
            end else if (ccnt_q == C_LAST) begin
               state_d = IDLE;
            end else begin
               ccnt_d = ccnt_q + 1'b1;
            end
         end
         CANCEL: begin
            if (!db_l && !db_r) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dir_q   <= L;
         timer_q <= '0;
         ccnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         timer_q <= timer_d;
         ccnt_q  <= ccnt_d;
      end
   end

   // Pure state decodes: reset clears them immediately, and a single dir_q
   // keeps left and right exclusive.
   assign bus.left      = ((state_q == ACTIVE) || (state_q == COMFORT)) && (dir_q == L);
   assign bus.right     = ((state_q == ACTIVE) || (state_q == COMFORT)) && (dir_q == R);
   assign bus.cancelled = (state_q == CANCEL);

endmodule
